// File: rtl/alu_bist.sv
// alu_bist: walks a fixed vector table through an external combinational ALU and scores the results (ALU_BIST_EXT_EN adds five edge-case vectors).
// Latency: N*(SETTLE+1) busy cycles per run, then a one-cycle Done pulse.
// Backpressure: none; Start is honoured only in IDLE and ignored while busy.
module alu_bist #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic [31:0] ALURes,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [3:0]  ALUOp,
    output logic        Busy,
    output logic        Done,
    output logic        Pass,
    output logic [4:0]  ErrCount,
    output logic [4:0]  FailIdx
);
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
`ifdef ALU_BIST_EXT_EN
    localparam logic [3:0] LAST_IDX = 4'd15;
`else
    localparam logic [3:0] LAST_IDX = 4'd10;
`endif
    localparam logic [4:0] NO_FAIL     = 5'h1F;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] exp;
    } vec_t;

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

    function automatic vec_t vec_lookup(input logic [3:0] idx);
        vec_t v;
        v = '0;
        case (idx)
            4'd0:  v = '{32'h0000_0000, 32'h0000_0000, OP_ADD,  32'h0000_0000};
            4'd1:  v = '{32'h0000_0003, 32'h0000_0005, OP_ADD,  32'h0000_0008};
            4'd2:  v = '{32'h0000_0003, 32'h0000_0005, OP_SUB,  32'hFFFF_FFFE};
            4'd3:  v = '{32'h0000_0001, 32'h0000_0002, OP_SLL,  32'h0000_0004};
            4'd4:  v = '{32'hFFFF_FFFE, 32'h0000_0003, OP_SLT,  32'h0000_0001};
            4'd5:  v = '{32'h0000_0002, 32'h0000_0003, OP_SLTU, 32'h0000_0001};
            4'd6:  v = '{32'h0000_0004, 32'h0000_0001, OP_SRL,  32'h0000_0002};
            4'd7:  v = '{32'hFFFF_FFF8, 32'h0000_0002, OP_SRA,  32'hFFFF_FFFE};
            4'd8:  v = '{32'h0000_0003, 32'h0000_0006, OP_XOR,  32'h0000_0005};
            4'd9:  v = '{32'h0000_0003, 32'h0000_0006, OP_OR,   32'h0000_0007};
            4'd10: v = '{32'h0000_0003, 32'h0000_0006, OP_AND,  32'h0000_0002};
`ifdef ALU_BIST_EXT_EN
            4'd11: v = '{32'h7FFF_FFFF, 32'h0000_0001, OP_ADD,  32'h8000_0000};
            4'd12: v = '{32'hFFFF_FFFF, 32'h0000_0001, OP_SLTU, 32'h0000_0000};
            4'd13: v = '{32'h8000_0000, 32'h0000_001F, OP_SRA,  32'hFFFF_FFFF};
            4'd14: v = '{32'h8000_0000, 32'h0000_001F, OP_SRL,  32'h0000_0001};
            4'd15: v = '{32'h0000_0001, 32'h0000_0021, OP_SLL,  32'h0000_0002};
`endif
            default: v = '0;
        endcase
        return v;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d, exp_q, exp_d;
    logic [3:0]  op_q, op_d;
    logic [4:0]  err_q, err_d, fidx_q, fidx_d;
    logic        pass_q, pass_d;
    logic        mism;
    logic [3:0]  load_idx;
    vec_t        ld_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            exp_q   <= '0;
            err_q   <= '0;
            fidx_q  <= NO_FAIL;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            exp_q   <= exp_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            pass_q  <= pass_d;
        end
    end

    // The expected value travels with the operands so CHECK compares against exp_q.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        exp_d    = exp_q;
        err_d    = err_q;
        fidx_d   = fidx_q;
        pass_d   = pass_q;
        Done     = 1'b0;
        mism     = (ALURes != exp_q);
        load_idx = (state_q == IDLE) ? 4'd0 : idx_q + 4'd1;
        ld_v     = vec_lookup(load_idx);
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = DRIVE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    {a_d, b_d, op_d, exp_d} = ld_v;
                    err_d   = '0;
                    fidx_d  = NO_FAIL;
                    pass_d  = 1'b0;
                end
            end
            DRIVE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CHECK: begin
                if (mism) begin
                    err_d = err_q + 5'd1;
                    if (fidx_q == NO_FAIL) fidx_d = {1'b0, idx_q};
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    pass_d  = !mism && (err_q == 5'd0);
                end else begin
                    state_d = DRIVE;
                    idx_d   = load_idx;
                    {a_d, b_d, op_d, exp_d} = ld_v;
                end
            end
            DONE: begin
                Done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign A        = a_q;
    assign B        = b_q;
    assign ALUOp    = op_q;
    assign Busy     = (state_q != IDLE);
    assign Pass     = pass_q;
    assign ErrCount = err_q;
    assign FailIdx  = fidx_q;
endmodule

// File: doc/alu_bist.md
ALU_BIST -- requirements
Module: alu_bist

Interface
REQ-001 SETTLE, default 1, number of cycles A/B/ALUOp are held before ALURes is sampled; legal range 1..15.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 Start  in  1  run request; sampled only in IDLE.
REQ-005 A  out  32  ALU operand A, registered.
REQ-006 B  out  32  ALU operand B, registered.
REQ-007 ALUOp  out  4  ALU opcode, registered; encoding ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
REQ-008 ALURes  in  32  result returned by the external combinational ALU.
REQ-009 Busy  out  1  high in every state except IDLE.
REQ-010 Done  out  1  one-cycle pulse at the end of a run.
REQ-011 Pass  out  1  last completed run had zero mismatches; held until the next Start is accepted.
REQ-012 ErrCount  out  5  mismatch count of the current or last run.
REQ-013 FailIdx  out  5  index of the first mismatching vector; 5'h1F means no mismatch.

Function
REQ-014 The block SHALL hold a fixed vector table, indexed as A, B, op -> expected: 0 (0,0,ADD->0); 1 (3,5,ADD->8); 2 (3,5,SUB->FFFFFFFE); 3 (1,2,SLL->4); 4 (-2,3,SLT->1); 5 (2,3,SLTU->1); 6 (4,1,SRL->2); 7 (-8,2,SRA->FFFFFFFE); 8 (3,6,XOR->5); 9 (3,6,OR->7); 10 (3,6,AND->2).
REQ-015 The block SHALL implement the FSM IDLE -> DRIVE -> CHECK -> (DRIVE | DONE) -> IDLE.
REQ-016 IDLE with Start=1 SHALL go to DRIVE. Index=0. A/B/ALUOp load vector 0. ErrCount=0. FailIdx=1F. Pass=0.
REQ-017 DRIVE SHALL last exactly SETTLE cycles, counted by an internal counter, then go to CHECK.
REQ-018 CHECK SHALL last 1 cycle and compare all 32 bits of ALURes with the expected value.
REQ-019 On a mismatch, CHECK SHALL increment ErrCount. If FailIdx=1F, it SHALL also load FailIdx with the current index.
REQ-020 CHECK on a non-last index SHALL increment the index, load the next vector onto A/B/ALUOp, and go to DRIVE.
REQ-021 CHECK on the last index SHALL go to DONE.
REQ-022 DONE SHALL last 1 cycle, assert Done, set Pass=(ErrCount==0) including any mismatch in the final CHECK, and go to IDLE.
REQ-023 Run length SHALL be N*(SETTLE+1) Busy cycles followed by the Done cycle, where N is the vector count.
REQ-024 Start while Busy SHALL be ignored.
REQ-025 Start held high SHALL restart the run on the cycle after DONE, after one IDLE cycle.
REQ-026 A/B/ALUOp SHALL keep the last vector's values in DONE and IDLE.

Reset
REQ-027 rst_n low SHALL immediately force the following, including mid-run: IDLE; index=0; A=0, B=0, ALUOp=0; Busy=0, Done=0, Pass=0, ErrCount=0, FailIdx=1F.
REQ-028 After reset release, the first Start SHALL begin a complete run from vector 0.

Configuration
REQ-029 With ALU_BIST_EXT_EN defined, the table SHALL append these five vectors, giving N=16:
- 11 (7FFFFFFF,1,ADD->80000000)
- 12 (FFFFFFFF,1,SLTU->0)
- 13 (80000000,31,SRA->FFFFFFFF)
- 14 (80000000,31,SRL->1)
- 15 (1,33,SLL->2; shift uses B[4:0])
REQ-030 Without ALU_BIST_EXT_EN, N=11 and vectors 11-15 SHALL not exist in the RTL.

Verification
REQ-031 Correct ALU model, SETTLE=1, Start pulse -> Busy 22 cycles, Done on cycle 23, Pass=1, ErrCount=0, FailIdx=1F.
REQ-032 ALU model whose SUB returns A+B -> ErrCount=1, FailIdx=2, Pass=0.
REQ-033 ALURes tied to 0 -> ErrCount=10, FailIdx=1, Pass=0.
REQ-034 Start held high for 60 cycles -> two full runs with exactly one IDLE cycle between them; Start pulses during Busy cause no restart.
REQ-035 rst_n low during cycle 10 of a run -> all outputs at reset values before the next edge; the next Start completes a full 22-cycle run with Pass=1.
REQ-036 ALU_BIST_EXT_EN defined, correct ALU, SETTLE=2 -> Busy 48 cycles, Done on cycle 49, Pass=1; an ALU using B[5:0] for SLL gives FailIdx=15.
